// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction fetch unit with PC, single-outstanding imem port,
//            PC-tagged instruction FIFO and redirect flush.
// Option   : IFU_EBREAK_HALT_EN - stop fetching once an ebreak word is buffered
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] instruction,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted
);
   localparam int                 c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int                 c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic               r_req_valid;
   logic               r_halted;
   logic [31:0]        r_pc;
   logic [31:0]        r_req_pc;
   logic [31:0]        r_fifo_data [FIFO_DEPTH];
   logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic [c_cnt_w-1:0] r_count;
   logic [c_cnt_w-1:0] w_count_next;
   logic               w_accept;
   logic               w_pop;
   logic               w_push;
   logic               w_space;
   logic               w_halt_set;
   logic               w_halted_next;

   assign w_accept     = r_req_valid & imem_req_ready;
   assign w_pop        = (r_count != '0) & inst_ready;
   // A redirect in the response cycle discards the word instead of buffering it.
   assign w_push       = (r_state == S_WAIT) & imem_resp_valid & ~redirect_valid &
                         ((r_count != c_depth) | w_pop);
   assign w_count_next = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
   assign w_space      = (w_count_next < c_depth);

`ifdef IFU_EBREAK_HALT_EN
   localparam logic [31:0] c_ebreak = 32'h0010_0073;
   assign w_halt_set = w_push & (imem_resp_data == c_ebreak);
`else
   assign w_halt_set = 1'b0;
`endif
   assign w_halted_next = r_halted | w_halt_set;

   always_comb begin
      w_state_next = r_state;
      if (redirect_valid) begin
         case (r_state)
            S_WAIT, S_FLUSH: w_state_next = imem_resp_valid ? (r_halted ? S_IDLE : S_REQ) : S_FLUSH;
            S_REQ:           w_state_next = w_accept ? S_FLUSH : (r_halted ? S_IDLE : S_REQ);
            default:         w_state_next = r_halted ? S_IDLE : S_REQ;
         endcase
      end else begin
         case (r_state)
            S_IDLE:  if (w_space && !r_halted) w_state_next = S_REQ;
            S_REQ:   if (w_accept) w_state_next = S_WAIT;
            S_WAIT:  if (imem_resp_valid) w_state_next = (w_space && !w_halted_next) ? S_REQ : S_IDLE;
            S_FLUSH: if (imem_resp_valid) w_state_next = r_halted ? S_IDLE : S_REQ;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_REQ;
         r_req_valid <= 1'b0;
         r_halted    <= 1'b0;
         r_pc        <= RESET_PC;
         r_req_pc    <= RESET_PC;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_data[i] <= '0;
            r_fifo_pc[i]   <= '0;
         end
      end else begin
         r_state     <= w_state_next;
         r_req_valid <= (w_state_next == S_REQ);
         r_halted    <= w_halted_next;
         if (redirect_valid)
            r_pc <= redirect_pc & 32'hFFFF_FFFC;
         else if (w_accept)
            r_pc <= r_pc + 32'd4;
         if (w_accept)
            r_req_pc <= r_pc;
         if (redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_fifo_data[r_wptr] <= imem_resp_data;
               r_fifo_pc[r_wptr]   <= r_req_pc;
               r_wptr              <= r_wptr + c_ptr_w'(1);
            end
            if (w_pop)
               r_rptr <= r_rptr + c_ptr_w'(1);
            r_count <= w_count_next;
         end
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_pc;
   assign inst_valid     = (r_count != '0);
   assign instruction    = r_fifo_data[r_rptr];
   assign inst_pc        = r_fifo_pc[r_rptr];
   assign halted         = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Self-checking bench for ifu_fetch: transaction-level fetch model,
//            bench-side memory and directed scenarios. Honours IFU_EBREAK_HALT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;
   localparam logic [31:0] RESET_PC   = 32'h8000_0000;
   localparam int          FIFO_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] instruction;
   logic [31:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halted;

   ifu_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .instruction(instruction), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(halted)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // bench memory state
   int          mem_lat   = 1;
   int          pend_cnt  = 0;
   logic [31:0] pend_addr = '0;
   logic        ebreak_on = 1'b0;

   // transaction-level model state
   logic [63:0] q[$];
   logic [31:0] exp_pc    = RESET_PC;
   logic        outst     = 1'b0;
   logic        drop_next = 1'b0;
   logic [31:0] out_addr  = '0;
   logic        halted_m  = 1'b0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_addr = '0;
   int          acc_count = 0;
   int          push_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (ebreak_on && a == 32'h8000_0008) return 32'h0010_0073;
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // memory: exactly one response per accepted request, mem_lat cycles later
   initial begin
      forever begin
         @(posedge clk);
         #1;
         imem_resp_valid = 1'b0;
         if (!rst_n) begin
            pend_cnt = 0;
         end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = mem_word(pend_addr);
            end
         end
      end
   end

   // compare process: check outputs against the model, then advance the model
   always @(negedge clk) begin
      logic acc;
      logic popv;
      if (!rst_n) begin
         chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
         chk("rst_inst_valid", 32'(inst_valid), 32'd0);
         chk("rst_halted", 32'(halted), 32'd0);
         q.delete();
         exp_pc    = RESET_PC;
         outst     = 1'b0;
         drop_next = 1'b0;
         halted_m  = 1'b0;
         prev_hold = 1'b0;
      end else begin
         chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("inst_pc", inst_pc, q[0][63:32]);
            chk("instruction", instruction, q[0][31:0]);
         end
         chk("halted", 32'(halted), 32'(halted_m));
         if (outst || halted_m) chk("req_quiet", 32'(imem_req_valid), 32'd0);
         if (prev_hold) begin
            chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
            chk("req_hold_addr", imem_req_addr, prev_addr);
         end
         chk("addr_align", 32'(imem_req_addr[1:0]), 32'd0);

         acc  = imem_req_valid && imem_req_ready;
         popv = inst_ready && (q.size() != 0) && !redirect_valid;
         if (acc) begin
            chk("acc_addr", imem_req_addr, exp_pc);
            chk("acc_space", 32'((q.size() < FIFO_DEPTH) && !outst), 32'd1);
            acc_count++;
            pend_cnt  = mem_lat;
            pend_addr = imem_req_addr;
         end
         if (popv) void'(q.pop_front());
         if (imem_resp_valid && outst) begin
            if (!redirect_valid && !drop_next) begin
               q.push_back({out_addr, imem_resp_data});
               push_count++;
`ifdef IFU_EBREAK_HALT_EN
               if (imem_resp_data == 32'h0010_0073) halted_m = 1'b1;
`endif
            end
            outst     = 1'b0;
            drop_next = 1'b0;
         end
         if (acc) begin
            outst    = 1'b1;
            out_addr = imem_req_addr;
            exp_pc   = imem_req_addr + 32'd4;
         end
         if (redirect_valid) begin
            q.delete();
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
            if (outst) drop_next = 1'b1;
         end
         prev_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
         prev_addr = imem_req_addr;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      int a0;
      int p0;
      int got;

      // ---- reset release, first fetches, backpressure from decoder ----
      inst_ready = 1'b0;
      do_reset();
      chk("t1_req_after_release", 32'(imem_req_valid), 32'd0);
      tick();
      chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t1_addr0", imem_req_addr, 32'h8000_0000);
      tick();
      tick();
      chk("t1_inst_valid", 32'(inst_valid), 32'd1);
      chk("t1_inst_pc0", inst_pc, 32'h8000_0000);
      chk("t1_inst0", instruction, 32'h9357_9BDF);
      chk("t1_addr1", imem_req_addr, 32'h8000_0004);
      chk("t1_req_valid1", 32'(imem_req_valid), 32'd1);
      tick();
      tick();
      chk("t2_full_req_low", 32'(imem_req_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_stall_req_low", 32'(imem_req_valid), 32'd0);
      end
      chk("t2_two_pushes", push_count, 32'd2);
      a0 = acc_count;
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("t2_refetch_valid", 32'(imem_req_valid), 32'd1);
      chk("t2_refetch_addr", imem_req_addr, 32'h8000_0008);
      chk("t2_head_pc", inst_pc, 32'h8000_0004);
      for (int i = 0; i < 4; i++) tick();
      chk("t2_one_new_req", acc_count, a0 + 1);
      chk("t2_req_low_again", 32'(imem_req_valid), 32'd0);

      // ---- redirect of an unaccepted request, then redirect in WAIT ----
      inst_ready     = 1'b1;
      imem_req_ready = 1'b0;
      tick();
      chk("t3_req_pending", 32'(imem_req_valid), 32'd1);
      chk("t3_pending_addr", imem_req_addr, 32'h8000_000C);
      chk("t3_head_after_pop", inst_pc, 32'h8000_0008);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0203;
      tick();
      redirect_valid = 1'b0;
      chk("t3_withdraw_valid", 32'(imem_req_valid), 32'd1);
      chk("t3_withdraw_addr", imem_req_addr, 32'h8000_0200);
      chk("t3_withdraw_flush", 32'(inst_valid), 32'd0);
      tick();
      tick();
      imem_req_ready = 1'b1;
      mem_lat        = 2;
      tick();
      chk("t3_in_wait", 32'(imem_req_valid), 32'd0);
      p0 = push_count;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      tick();
      redirect_valid = 1'b0;
      mem_lat        = 1;
      chk("t3_flush_req", 32'(imem_req_valid), 32'd0);
      chk("t3_flush_inst", 32'(inst_valid), 32'd0);
      tick();
      chk("t3_new_req", 32'(imem_req_valid), 32'd1);
      chk("t3_new_addr", imem_req_addr, 32'h8000_0100);
      chk("t3_no_stale_valid", 32'(inst_valid), 32'd0);
      chk("t3_no_stale_push", push_count, p0);
      tick();
      tick();
      chk("t3_fetch_valid", 32'(inst_valid), 32'd1);
      chk("t3_fetch_pc", inst_pc, 32'h8000_0100);
      chk("t3_fetch_inst", instruction, 32'h9357_9ADF);

      // ---- simultaneous push and pop keeps count and order ----
      inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("t4_valid", 32'(inst_valid), 32'd1);
      chk("t4_head_pc", inst_pc, 32'h8000_0004);
      chk("t4_head_inst", instruction, 32'h9357_9BDB);
      chk("t4_space_req", 32'(imem_req_valid), 32'd1);
      chk("t4_space_addr", imem_req_addr, 32'h8000_0008);
      tick();
      tick();
      chk("t4_full_head", inst_pc, 32'h8000_0004);
      chk("t4_full_req_low", 32'(imem_req_valid), 32'd0);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("t4_order_pc", inst_pc, 32'h8000_0008);
      chk("t4_order_inst", instruction, 32'h9357_9BD7);

      // ---- asynchronous reset while waiting for a response ----
      mem_lat    = 2;
      inst_ready = 1'b1;
      a0  = acc_count;
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         tick();
         if (acc_count != a0) got = 1;
      end
      chk("t6_reached_wait", 32'(got), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_req_now", 32'(imem_req_valid), 32'd0);
      chk("t6_inst_now", 32'(inst_valid), 32'd0);
      chk("t6_halted_now", 32'(halted), 32'd0);
      mem_lat = 1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_restart_valid", 32'(imem_req_valid), 32'd1);
      chk("t6_restart_addr", imem_req_addr, 32'h8000_0000);

      // ---- ebreak at 0x8000_0008 ----
      ebreak_on  = 1'b1;
      inst_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 7; i++) tick();
      chk("t5_ebreak_valid", 32'(inst_valid), 32'd1);
      chk("t5_ebreak_pc", inst_pc, 32'h8000_0008);
      chk("t5_ebreak_word", instruction, 32'h0010_0073);
      a0 = acc_count;
`ifdef IFU_EBREAK_HALT_EN
      chk("t5_halted", 32'(halted), 32'd1);
      chk("t5_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      chk("t5_drained", 32'(inst_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0300;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t5_stays_halted", 32'(halted), 32'd1);
      chk("t5_no_restart", acc_count, a0);
`else
      chk("t5_not_halted", 32'(halted), 32'd0);
      chk("t5_continue_addr", imem_req_addr, 32'h8000_000C);
      for (int i = 0; i < 4; i++) tick();
      chk("t5_fetch_continues", 32'(acc_count > a0), 32'd1);
`endif
      inst_ready = 1'b0;
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
